apb_master_bridge: RTL and testbench

- APB master state machine that turns the flat request bus (`i_ptransfer`, `i_prwrite`, `i_pwaddr`, `i_pwdata`, `i_praddr`) into APB3 bus cycles.
- It drives two slaves and returns read data on `o_prdata`.
- It sits between the request bus, which the testbench agent drives, and the two APB slave memories.
- Address MSB selects the target slave.

---
 rtl/apb_master_bridge.sv | 155 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Purpose: APB3 master. Turns the flat request bus into SETUP/ACCESS cycles on two slaves; addr MSB picks the slave.
// Latency: a request seen in IDLE completes at the earliest 2 edges later (1 SETUP + 1 ACCESS cycle).
// Backpressure: i_pready low stretches ACCESS up to TIMEOUT cycles, then the transfer is aborted with an error pulse.
//
// Ports:
//   pclk, preset                      clock, synchronous active-high reset
//   i_ptransfer/i_prwrite/i_pwaddr/
//   i_pwdata/i_praddr                 request bus; taken in IDLE or on a completion edge
//   o_psel1/o_psel2/o_penable/
//   o_pwrite/o_paddr/o_pwdata         APB master outputs
//   i_pready/i_prdata/i_pslverr       muxed response of the selected slave
//   o_prdata                          data of the last completed read
//   o_pslverr                         1-cycle pulse: slave error or timeout
//   o_busy                            high in SETUP or ACCESS
module apb_master_bridge #(
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          i_ptransfer,
  input  logic          i_prwrite,
  input  logic [AW-1:0] i_pwaddr,
  input  logic [DW-1:0] i_pwdata,
  input  logic [AW-1:0] i_praddr,
  output logic [DW-1:0] o_prdata,
  output logic          o_psel1,
  output logic          o_psel2,
  output logic          o_penable,
  output logic          o_pwrite,
  output logic [AW-2:0] o_paddr,
  output logic [DW-1:0] o_pwdata,
  input  logic          i_pready,
  input  logic [DW-1:0] i_prdata,
  input  logic          i_pslverr,
  output logic          o_pslverr,
  output logic          o_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] prdata_q;
  logic          pslverr_q;
  logic          done;
  logic          expire;
  logic          capture;

  // A transfer completes on any ACCESS edge with pready high. It expires on the
  // edge that would make the TIMEOUT-th consecutive not-ready ACCESS cycle count.
  assign done    = (state == ACCESS) && i_pready;
  assign expire  = (state == ACCESS) && !i_pready && (wait_cnt == CW'(TIMEOUT - 1));
  // New requests are only taken when the bus is free: IDLE, or a completion edge.
  assign capture = i_ptransfer && ((state == IDLE) || done);

  // State register
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = capture ? SETUP : IDLE;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (done) begin
          state_nxt = capture ? SETUP : IDLE;
        end else if (expire) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = ACCESS;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers
  always_ff @(posedge pclk) begin
    if (preset) begin
      wait_cnt  <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      if (state_nxt == SETUP) begin
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !i_pready) begin
        wait_cnt <= wait_cnt + CW'(1);
      end

      if (capture) begin
        write_q <= i_prwrite;
        addr_q  <= i_prwrite ? i_pwaddr : i_praddr;
        // Reads drive zero write data on the bus.
        wdata_q <= i_prwrite ? i_pwdata : '0;
      end

      if (done && !write_q) begin
        prdata_q <= i_prdata;
      end

      pslverr_q <= (done && i_pslverr) || expire;
    end
  end

  // Output logic: selects/enable follow the state, address and data hold in IDLE.
  always_comb begin
    o_psel1   = 1'b0;
    o_psel2   = 1'b0;
    o_penable = 1'b0;
    o_busy    = 1'b0;
    unique case (state)
      SETUP: begin
        o_psel1 = !addr_q[AW-1];
        o_psel2 = addr_q[AW-1];
        o_busy  = 1'b1;
      end
      ACCESS: begin
        o_psel1   = !addr_q[AW-1];
        o_psel2   = addr_q[AW-1];
        o_penable = 1'b1;
        o_busy    = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_paddr   = addr_q[AW-2:0];
  assign o_pwrite  = write_q;
  assign o_pwdata  = wdata_q;
  assign o_prdata  = prdata_q;
  assign o_pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset;
  logic          i_ptransfer;
  logic          i_prwrite;
  logic [AW-1:0] i_pwaddr;
  logic [DW-1:0] i_pwdata;
  logic [AW-1:0] i_praddr;
  logic [DW-1:0] o_prdata;
  logic          o_psel1;
  logic          o_psel2;
  logic          o_penable;
  logic          o_pwrite;
  logic [AW-2:0] o_paddr;
  logic [DW-1:0] o_pwdata;
  logic          i_pready;
  logic [DW-1:0] i_prdata;
  logic          i_pslverr;
  logic          o_pslverr;
  logic          o_busy;

  apb_master_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .pclk       (pclk),
    .preset     (preset),
    .i_ptransfer(i_ptransfer),
    .i_prwrite  (i_prwrite),
    .i_pwaddr   (i_pwaddr),
    .i_pwdata   (i_pwdata),
    .i_praddr   (i_praddr),
    .o_prdata   (o_prdata),
    .o_psel1    (o_psel1),
    .o_psel2    (o_psel2),
    .o_penable  (o_penable),
    .o_pwrite   (o_pwrite),
    .o_paddr    (o_paddr),
    .o_pwdata   (o_pwdata),
    .i_pready   (i_pready),
    .i_prdata   (i_prdata),
    .i_pslverr  (i_pslverr),
    .o_pslverr  (o_pslverr),
    .o_busy     (o_busy)
  );

  always #5 pclk = ~pclk;

  // One transaction as the requester/slave sees it: waits = number of
  // not-ready ACCESS cycles the slave inserts before pready.
  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            waits;
    bit            err;
    bit            b2b;
  } txn_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_rdata;
  bit            chained;
  txn_t          q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic [DW-1:0] rd, input int w, input bit e, input bit b);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = wd; t.rdata = rd; t.waits = w; t.err = e; t.b2b = b;
    return t;
  endfunction

  task automatic tick();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic drive_req(input txn_t t);
    i_ptransfer = 1'b1;
    i_prwrite   = t.wr;
    i_pwaddr    = t.wr ? t.addr : AW'($urandom);
    i_praddr    = t.wr ? AW'($urandom) : t.addr;
    i_pwdata    = t.wdata;
  endtask

  // Random request-bus activity the bridge must ignore.
  task automatic noise_req();
    i_ptransfer = 1'($urandom);
    i_prwrite   = 1'($urandom);
    i_pwaddr    = AW'($urandom);
    i_praddr    = AW'($urandom);
    i_pwdata    = DW'($urandom);
  endtask

  task automatic check_bus(input string tag, input txn_t t, input bit en);
    logic [DW-1:0] wd;
    wd = t.wr ? t.wdata : '0;
    check({tag, ".psel1"},   32'(o_psel1),   32'(!t.addr[AW-1]));
    check({tag, ".psel2"},   32'(o_psel2),   32'(t.addr[AW-1]));
    check({tag, ".penable"}, 32'(o_penable), 32'(en));
    check({tag, ".paddr"},   32'(o_paddr),   32'(t.addr[AW-2:0]));
    check({tag, ".pwrite"},  32'(o_pwrite),  32'(t.wr));
    check({tag, ".pwdata"},  32'(o_pwdata),  32'(wd));
    check({tag, ".busy"},    32'(o_busy),    32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".psel1"},   32'(o_psel1),   32'd0);
    check({tag, ".psel2"},   32'(o_psel2),   32'd0);
    check({tag, ".penable"}, 32'(o_penable), 32'd0);
    check({tag, ".pwrite"},  32'(o_pwrite),  32'd0);
    check({tag, ".paddr"},   32'(o_paddr),   32'd0);
    check({tag, ".pwdata"},  32'(o_pwdata),  32'd0);
    check({tag, ".prdata"},  32'(o_prdata),  32'd0);
    check({tag, ".pslverr"}, 32'(o_pslverr), 32'd0);
    check({tag, ".busy"},    32'(o_busy),    32'd0);
  endtask

  // Runs one transfer from its SETUP cycle to IDLE (or to the next SETUP when
  // chained). Called at a negedge with the bridge in IDLE unless chained.
  task automatic run_txn(input txn_t t, input bit have_nxt, input txn_t nxt);
    bit completes;
    int acc_len;
    if (!chained) begin
      drive_req(t);
      tick();
    end
    check_bus("setup", t, 1'b0);
    noise_req();
    i_pready  = 1'($urandom);
    i_pslverr = 1'($urandom);
    tick();
    completes = t.waits < TO;
    acc_len   = completes ? t.waits + 1 : TO;
    for (int k = 0; k < acc_len; k++) begin
      check_bus("access", t, 1'b1);
      check("access.pslverr", 32'(o_pslverr), 32'd0);
      if (completes && k == acc_len - 1) begin
        i_pready  = 1'b1;
        i_prdata  = t.rdata;
        i_pslverr = t.err;
        chained   = have_nxt && t.b2b;
        if (chained) begin
          drive_req(nxt);
        end else begin
          noise_req();
          i_ptransfer = 1'b0;
        end
      end else begin
        i_pready  = 1'b0;
        i_prdata  = DW'($urandom);
        i_pslverr = 1'($urandom);
        noise_req();
      end
      tick();
    end
    if (!completes) chained = 1'b0;
    if (completes && !t.wr) exp_rdata = t.rdata;
    check("done.pslverr", 32'(o_pslverr), 32'(!completes || t.err));
    check("done.prdata",  32'(o_prdata),  32'(exp_rdata));
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    if (!chained) begin
      i_ptransfer = 1'b0;
      check("idle.busy",    32'(o_busy),    32'd0);
      check("idle.psel1",   32'(o_psel1),   32'd0);
      check("idle.psel2",   32'(o_psel2),   32'd0);
      check("idle.penable", 32'(o_penable), 32'd0);
      check("idle.paddr",   32'(o_paddr),   32'(t.addr[AW-2:0]));
      check("idle.pwrite",  32'(o_pwrite),  32'(t.wr));
      tick();
      check("idle.pslverr", 32'(o_pslverr), 32'd0);
      check("idle.busy2",   32'(o_busy),    32'd0);
    end
  endtask

  initial begin
    int   w;
    txn_t t;
    preset      = 1'b1;
    i_ptransfer = 1'b1;
    i_prwrite   = 1'b1;
    i_pwaddr    = '1;
    i_praddr    = '1;
    i_pwdata    = '1;
    i_pready    = 1'b1;
    i_prdata    = '1;
    i_pslverr   = 1'b1;
    exp_rdata   = '0;
    chained     = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    preset      = 1'b0;
    i_ptransfer = 1'b0;
    i_pready    = 1'b0;
    i_pslverr   = 1'b0;
    tick();

    // Directed cases, then randomized traffic.
    q.push_back(mk(1'b1, 9'h155, 8'hA5, 8'h00,  0,     1'b0, 1'b0));
    q.push_back(mk(1'b0, 9'h022, 8'h99, 8'h3C,  3,     1'b0, 1'b0));
    q.push_back(mk(1'b1, 9'h010, 8'h5A, 8'h00,  0,     1'b0, 1'b1));
    q.push_back(mk(1'b0, 9'h110, 8'h12, 8'h77,  1,     1'b0, 1'b0));
    q.push_back(mk(1'b0, 9'h0F0, 8'h00, 8'hEE,  40,    1'b0, 1'b1));
    q.push_back(mk(1'b0, 9'h1C3, 8'h00, 8'hE1,  2,     1'b1, 1'b0));
    q.push_back(mk(1'b1, 9'h0AA, 8'h3F, 8'h00,  TO-1,  1'b0, 1'b0));
    for (int i = 0; i < 80; i++) begin
      w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 2, TO + 4))
                                       : int'($urandom_range(0, 3));
      q.push_back(mk(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), w,
                     ($urandom_range(0, 3) == 0), 1'($urandom)));
    end
    for (int i = 0; i < q.size(); i++) begin
      run_txn(q[i], (i + 1 < q.size()), q[(i + 1 < q.size()) ? i + 1 : i]);
    end

    // Reset in the middle of an ACCESS with wait states.
    t = mk(1'b0, 9'h1AB, 8'h00, 8'hC7, 10, 1'b0, 1'b0);
    drive_req(t);
    tick();
    i_ptransfer = 1'b0;
    tick();
    i_pready = 1'b0;
    tick();
    check("midrst.penable", 32'(o_penable), 32'd1);
    preset      = 1'b1;
    i_pready    = 1'b1;
    i_pslverr   = 1'b1;
    i_ptransfer = 1'b1;
    tick();
    exp_rdata = '0;
    check_all_zero("midrst");
    preset      = 1'b0;
    i_pready    = 1'b0;
    i_pslverr   = 1'b0;
    i_ptransfer = 1'b0;
    tick();
    chained = 1'b0;
    t = mk(1'b0, 9'h0C4, 8'h00, 8'h6D, 1, 1'b0, 1'b0);
    run_txn(t, 1'b0, t);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
